// File: rtl/cart_flash_reader.sv
// Cartridge ROM reader: wakes an SPI NOR flash, then serves byte reads
// (0x03 + 24-bit address) over a mode-0 master at clk/2.
// Ports: clk, rst_n (async, active-low); req_valid/req_addr/req_ready
// request side; rsp_valid/rsp_data response side; flash_sck/csn/mosi/miso.
// Build option CART_FLASH_SEQ_EN: CSN is held low between reads so an
// address that follows the previous one streams the next byte directly.
module cart_flash_reader #(
  parameter logic [23:0] FLASH_BASE  = 24'h100000,
  parameter logic [15:0] WAKE_CYCLES = 16'd200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [14:0] req_addr,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        flash_sck,
  output logic        flash_csn,
  output logic        flash_mosi,
  input  logic        flash_miso
);

  typedef enum logic [2:0] {
    WAKE, WAKE_WAIT, IDLE, CMD, DATA, DONE
  } state_t;

  state_t      state_q, state_d;
  logic        sck_q, sck_d;
  logic        csn_q, csn_d;
  logic        mosi_q, mosi_d;
  logic        vld_q, vld_d;
  logic [31:0] osr_q, osr_d;
  logic [7:0]  isr_q, isr_d;
  logic [7:0]  data_q, data_d;
  logic [4:0]  bit_q, bit_d;
  logic [15:0] cnt_q, cnt_d;
  logic        accept;
  logic        seq_hit;
  logic        keep_cs;
  logic [15:0] lead;
  logic [4:0]  last_bit;
  logic [23:0] flash_addr;

  assign req_ready  = (state_q == IDLE);
  assign accept     = req_ready && req_valid;
  assign flash_addr = FLASH_BASE + {9'b0, req_addr};

`ifdef CART_FLASH_SEQ_EN
  logic [14:0] prev_q;
  logic        prev_ok_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q    <= '0;
      prev_ok_q <= 1'b0;
    end else if (accept) begin
      prev_q    <= req_addr;
      prev_ok_q <= 1'b1;
    end
  end

  // Streaming only continues while CSN is still low from the last read.
  assign seq_hit = prev_ok_q && !csn_q &&
                   (prev_q != 15'h7FFF) &&
                   (req_addr == prev_q + 15'd1);
  assign keep_cs = 1'b1;
  assign lead    = 16'd2;
`else
  assign seq_hit = 1'b0;
  assign keep_cs = 1'b0;
  assign lead    = 16'd0;
`endif

  assign last_bit = (state_q == WAKE) ? 5'd7 : 5'd31;

  always_comb begin
    state_d = state_q;
    sck_d   = sck_q;
    csn_d   = csn_q;
    mosi_d  = mosi_q;
    vld_d   = 1'b0;
    osr_d   = osr_q;
    isr_d   = isr_q;
    data_d  = data_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      WAKE, CMD: begin
        // cnt_q is the CSN-high lead-in before a fresh frame.
        if (cnt_q != 16'd0) begin
          cnt_d  = cnt_q - 16'd1;
          csn_d  = 1'b1;
          mosi_d = 1'b0;
        end else if (csn_q) begin
          csn_d  = 1'b0;
          mosi_d = osr_q[31];
        end else if (!sck_q) begin
          sck_d = 1'b1;
        end else begin
          sck_d  = 1'b0;
          bit_d  = bit_q + 5'd1;
          osr_d  = {osr_q[30:0], 1'b0};
          mosi_d = osr_q[30];
          if (bit_q == last_bit) begin
            bit_d  = 5'd0;
            mosi_d = 1'b0;
            if (state_q == WAKE) begin
              csn_d   = 1'b1;
              state_d = WAKE_WAIT;
            end else begin
              state_d = DATA;
            end
          end
        end
      end
      WAKE_WAIT: begin
        cnt_d = cnt_q + 16'd1;
        if ({1'b0, cnt_q} + 17'd1 >= {1'b0, WAKE_CYCLES}) begin
          cnt_d   = 16'd0;
          state_d = IDLE;
        end
      end
      IDLE: begin
        if (accept) begin
          osr_d   = {8'h03, flash_addr};
          bit_d   = 5'd0;
          cnt_d   = seq_hit ? 16'd0 : lead;
          state_d = seq_hit ? DATA : CMD;
        end
      end
      DATA: begin
        if (!sck_q) begin
          sck_d = 1'b1;
        end else begin
          // Sample on the edge that drops SCK.
          sck_d = 1'b0;
          isr_d = {isr_q[6:0], flash_miso};
          bit_d = bit_q + 5'd1;
          if (bit_q == 5'd7) begin
            bit_d   = 5'd0;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        vld_d   = 1'b1;
        data_d  = isr_q;
        csn_d   = keep_cs ? csn_q : 1'b1;
        state_d = IDLE;
      end
      default: state_d = WAKE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAKE;
      sck_q   <= 1'b0;
      csn_q   <= 1'b1;
      mosi_q  <= 1'b0;
      vld_q   <= 1'b0;
      osr_q   <= 32'hAB00_0000;
      isr_q   <= 8'h00;
      data_q  <= 8'h00;
      bit_q   <= 5'd0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      sck_q   <= sck_d;
      csn_q   <= csn_d;
      mosi_q  <= mosi_d;
      vld_q   <= vld_d;
      osr_q   <= osr_d;
      isr_q   <= isr_d;
      data_q  <= data_d;
      bit_q   <= bit_d;
      cnt_q   <= cnt_d;
    end
  end

  assign flash_sck  = sck_q;
  assign flash_csn  = csn_q;
  assign flash_mosi = mosi_q;
  assign rsp_valid  = vld_q;
  assign rsp_data   = data_q;

endmodule

// File: tb/tb_cart_flash_reader.sv
// Bench for cart_flash_reader: SPI flash model, request driver,
// response scoreboard and wake/reset checks.
`timescale 1ns/1ps
module tb_cart_flash_reader;

  localparam logic [23:0] BASE = 24'h100000;
  localparam int WAKE_N = 200;
`ifdef CART_FLASH_SEQ_EN
  localparam bit SEQ = 1'b1;
  localparam int LAT_FULL = 84;
`else
  localparam bit SEQ = 1'b0;
  localparam int LAT_FULL = 82;
`endif
  localparam int LAT_SEQ = 17;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic [14:0] req_addr = '0;
  logic        req_ready;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        flash_sck, flash_csn, flash_mosi;
  logic        flash_miso = 1'b0;

  cart_flash_reader dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .flash_sck(flash_sck), .flash_csn(flash_csn),
    .flash_mosi(flash_mosi), .flash_miso(flash_miso)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  function automatic logic [7:0] fbyte(input logic [23:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'h68;
  endfunction

  // ---------------- flash model ----------------
  int          fbits = 0;
  logic [31:0] fsr = '0;
  logic [23:0] faddr = '0;
  logic        frd = 1'b0;
  int          last_bits = 0;
  logic [7:0]  last_byte = '0;
  logic [31:0] exp_cmd_q[$];
  logic [31:0] ecmd;
  logic [7:0]  fb;
  int          bi;

  always @(negedge flash_csn) begin
    fbits = 0;
    fsr = '0;
    frd = 1'b0;
  end

  always @(posedge flash_csn) begin
    last_bits = fbits;
    last_byte = fsr[7:0];
  end

  always @(posedge flash_sck) begin
    if (!flash_csn) begin
      if (fbits < 32) fsr = {fsr[30:0], flash_mosi};
      fbits++;
      if (fbits == 32) begin
        faddr = fsr[23:0];
        frd = (fsr[31:24] == 8'h03);
        total++;
        if (exp_cmd_q.size() == 0) begin
          bad++;
          $display("FAIL cmd_extra: got %h, expected none", fsr);
        end else begin
          ecmd = exp_cmd_q.pop_front();
          if (fsr !== ecmd) begin
            bad++;
            $display("FAIL cmd: got %h, expected %h", fsr, ecmd);
          end
        end
      end
    end
  end

  always @(negedge flash_sck) begin
    if (!flash_csn && frd && fbits >= 32) begin
      fb = fbyte(faddr + 24'((fbits - 32) / 8));
      bi = 7 - ((fbits - 32) % 8);
      flash_miso = fb[bi];
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [7:0] d;
    int         c;
  } exp_t;
  exp_t rsp_q[$];
  exp_t er;

  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      total++;
      if (rsp_q.size() == 0) begin
        bad++;
        $display("FAIL rsp_extra: got %h at cycle %0d, expected none",
                 rsp_data, cyc);
      end else begin
        er = rsp_q.pop_front();
        if (rsp_data !== er.d) begin
          bad++;
          $display("FAIL rsp_data: got %h, expected %h", rsp_data, er.d);
        end
        total++;
        if (cyc != er.c) begin
          bad++;
          $display("FAIL rsp_cycle: got %0d, expected %0d", cyc, er.c);
        end
      end
    end
  end

  int pin_bad = 0;
  always @(negedge clk) begin
    if (cyc > 0 && flash_csn && (flash_mosi || flash_sck)) pin_bad++;
  end

  // ---------------- reference model state ----------------
  int pv = -1;
  bit stream_open = 1'b0;

  task automatic do_req(input logic [14:0] a, input bit keep,
                        output int acc, output int lat);
    int n;
    bit sq;
    logic [23:0] fa;
    exp_t e;
    n = 0;
    req_valid = 1'b1;
    req_addr = a;
    while (!req_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!req_ready) begin
      bad++;
      $display("FAIL accept_timeout: got ready=0, expected 1");
      acc = -1;
      lat = 0;
      req_valid = 1'b0;
      return;
    end
    acc = cyc + 1;
    sq = SEQ && stream_open && pv >= 0 && pv != 32'h7FFF &&
         int'(a) == pv + 1;
    fa = BASE + {9'b0, a};
    lat = sq ? LAT_SEQ : LAT_FULL;
    if (!sq) exp_cmd_q.push_back({8'h03, fa});
    e.d = fbyte(fa);
    e.c = acc + lat;
    rsp_q.push_back(e);
    pv = int'(a);
    stream_open = 1'b1;
    @(negedge clk);
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic wake_check();
    int n;
    int rc;
    n = 0;
    while (flash_csn && n < 100) begin
      @(negedge clk);
      n++;
    end
    while (!flash_csn && n < 200) begin
      @(negedge clk);
      n++;
    end
    rc = cyc;
    total++;
    if (last_bits != 8 || last_byte !== 8'hAB) begin
      bad++;
      $display("FAIL wake_frame: got %0d bits %h, expected 8 bits ab",
               last_bits, last_byte);
    end
    n = 0;
    while (!req_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (cyc - rc != WAKE_N) begin
      bad++;
      $display("FAIL wake_wait: got %0d, expected %0d", cyc - rc, WAKE_N);
    end
  endtask

  task automatic check_reset_pins(input string nm);
    total++;
    if ({flash_csn, flash_sck, flash_mosi, req_ready, rsp_valid} !== 5'b10000 ||
        rsp_data !== 8'h00) begin
      bad++;
      $display("FAIL %s: got csn%b sck%b mosi%b rdy%b vld%b d%h, expected 1 0 0 0 0 00",
               nm, flash_csn, flash_sck, flash_mosi, req_ready,
               rsp_valid, rsp_data);
    end
  endtask

  initial begin
    int acc, lat, pacc, plat, n;
    logic [14:0] a;
    repeat (2) @(negedge clk);
    check_reset_pins("reset_state");
    rst_n = 1'b1;
    wake_check();

    // directed boundaries
    do_req(15'h0123, 1'b0, acc, lat);
    repeat (90) @(negedge clk);
    do_req(15'h0124, 1'b0, acc, lat);
    do_req(15'h7FFF, 1'b0, acc, lat);
    do_req(15'h0000, 1'b0, acc, lat);
    do_req(15'h0001, 1'b0, acc, lat);

    // random, with a bias toward sequential addresses
    for (int i = 0; i < 16; i++) begin
      if ($urandom_range(0, 2) == 0 && pv >= 0) a = 15'(pv + 1);
      else a = 15'($urandom);
      do_req(a, 1'b0, acc, lat);
      repeat ($urandom_range(0, 4)) @(negedge clk);
    end

    // request held high: each acceptance on the first IDLE cycle
    do_req(15'($urandom), 1'b1, pacc, plat);
    for (int i = 0; i < 4; i++) begin
      do_req(15'($urandom) | 15'h4000, 1'b1, acc, lat);
      total++;
      if (acc != pacc + plat + 1) begin
        bad++;
        $display("FAIL held_gap: got accept %0d, expected %0d",
                 acc, pacc + plat + 1);
      end
      pacc = acc;
      plat = lat;
    end
    req_valid = 1'b0;
    repeat (100) @(negedge clk);

    // reset 40 cycles into a read
    do_req(15'h2222, 1'b0, acc, lat);
    while (cyc < acc + 40) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_pins("reset_abort");
    rsp_q.delete();
    exp_cmd_q.delete();
    pv = -1;
    stream_open = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wake_check();

    do_req(15'h0123, 1'b0, acc, lat);
    do_req(15'h0124, 1'b0, acc, lat);

    n = 0;
    while (rsp_q.size() != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    total++;
    if (rsp_q.size() != 0 || exp_cmd_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d rsp %0d cmd pending, expected 0",
               rsp_q.size(), exp_cmd_q.size());
    end
    total++;
    if (pin_bad != 0) begin
      bad++;
      $display("FAIL idle_pins: got %0d violations, expected 0", pin_bad);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cart_flash_reader.md
CART_FLASH_READER -- requirements
Module: cart_flash_reader

Interface
REQ-001 Parameter FLASH_BASE, default 24'h100000: flash byte offset of cartridge ROM byte 0.
REQ-002 Parameter WAKE_CYCLES, default 16'd200: idle clk cycles after the wake command before first read.
REQ-003 clk  input  1  core clock; SPI SCK runs at clk/2.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  read request from the cartridge-bus bridge.
REQ-006 req_addr  input  15  cartridge ROM byte address (0x0000-0x7FFF).
REQ-007 req_ready  output  1  high only when a request can be accepted.
REQ-008 rsp_valid  output  1  one-cycle pulse marking rsp_data valid.
REQ-009 rsp_data  output  8  byte read from flash; holds its value until the next rsp_valid.
REQ-010 flash_sck / flash_csn / flash_mosi  output  1 each  SPI mode-0 master pins.
REQ-011 flash_miso  input  1  SPI data from flash.

Function
REQ-012 States: WAKE, WAKE_WAIT, IDLE, CMD, DATA, DONE; reset enters WAKE.
REQ-013 WAKE: CSN low, shift 8'hAB MSB-first, then CSN high and go to WAKE_WAIT.
REQ-014 WAKE_WAIT: count WAKE_CYCLES clk cycles, then go to IDLE.
REQ-015 IDLE: req_ready=1; acceptance occurs on a clk edge where req_valid && req_ready.
REQ-016 Flash address = FLASH_BASE + {9'b0, req_addr}, modulo 2^24, latched at acceptance.
REQ-017 CMD: 32 bits out, MSB-first: 8'h03, then address[23:0].
REQ-018 DATA: 8 bits in, MSB-first, into a shift register.
REQ-019 Bit timing: MOSI changes only while SCK=0; SCK high for 1 clk, low for 1 clk; MISO is sampled on the clk edge that drives SCK 1->0.
REQ-020 Non-sequential read: CSN falls on edge 1 after acceptance; rsp_valid is high during cycle 82; CSN rises on that same edge.
REQ-021 DONE lasts one cycle: rsp_data loads, rsp_valid pulses, then return to IDLE.
REQ-022 req_ready is 0 in every state except IDLE; req_valid outside IDLE is ignored and never queued.
REQ-023 SCK idles low; MOSI is 0 whenever CSN is high.
REQ-024 Back-to-back: a request held high through DONE is accepted on the first IDLE cycle, so the minimum gap between rsp_valid pulses is 83 cycles.

Reset
REQ-025 Asserting rst_n=0 forces, without waiting for clk: csn=1, sck=0, mosi=0, req_ready=0, rsp_valid=0, rsp_data=8'h00, state=WAKE, all counters 0.
REQ-026 Reset mid-CMD or mid-DATA aborts the transfer with no rsp_valid; the wake sequence reruns after release.
REQ-027 WAKE starts on the first clk edge with rst_n=1.

Configuration
REQ-028 Macro CART_FLASH_SEQ_EN compiled in: after DONE, CSN stays low.
REQ-029 With CART_FLASH_SEQ_EN, a request with req_addr == previous req_addr + 1 (no 0x7FFF->0x0000 wrap) skips CMD and shifts 8 DATA bits only; rsp_valid is high in cycle 17 after acceptance.
REQ-030 With CART_FLASH_SEQ_EN, a non-sequential request raises CSN for 2 cycles, then performs the full transfer; rsp_valid is high in cycle 84.
REQ-031 Without CART_FLASH_SEQ_EN: every read is non-sequential per REQ-020, and CSN always rises at DONE.

Verification
REQ-032 Release reset -> MOSI carries 0xAB on 8 SCK rises, CSN returns high, and req_ready stays 0 until 200 cycles later.
REQ-033 Flash model byte 0x100123=0x5A, request addr 0x0123 -> MOSI bytes 03 10 01 23; rsp_data=0x5A with rsp_valid exactly 82 cycles after acceptance.
REQ-034 With CART_FLASH_SEQ_EN: requests 0x0123 then 0x0124 -> second rsp_valid 17 cycles after its acceptance with no CSN pulse; request 0x7FFF then 0x0000 -> full transfer to 0x100000.
REQ-035 Pulse rst_n low at cycle 40 of a read -> CSN high and SCK 0 immediately, no rsp_valid, and the wake sequence repeats.
REQ-036 req_valid held high continuously -> no acceptance outside IDLE, and successive rsp_valid pulses are exactly 83 cycles apart.
